uart_rcv: RTL and testbench
===========================

Name: uart_rcv

Overview:
- UART receiver; the far end of the command link driven by UART_tx (8N1, LSB first, idle high).
- Sits inside Segway behind the RX pin and feeds received command bytes (e.g. 8'h67 'g' for go, 8'h73 's' for stop) to the authorization block.
- Provides a ready/clear handshake, framing-error detection and overrun detection.

Parameters:
- BAUD_DIV, 5208, clocks per bit (100 MHz / 19200 baud); legal range 16..65535.
- HALF_DIV, BAUD_DIV/2, clocks from the detected start edge to the start-bit midpoint.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous active-high reset.
- RX  input  1  serial input, asynchronous to clk, idle high.
- clr_rdy  input  1  consumer acknowledge; clears rdy.
- rx_data  output  8  last received byte.
- rdy  output  1  high while rx_data holds an unacknowledged byte.
- frm_err  output  1  stop bit of the last frame sampled low; sticky until clr_rdy.
- ovr_err  output  1  a new byte arrived while rdy was still high; sticky until clr_rdy.

Behaviour:
- Reset values:
  - rx_data = 8'h00; rdy = 0; frm_err = 0; ovr_err = 0.
  - State = IDLE; synchronizer flops preset to 1, so no false start is seen after reset.
- Synchronizer: RX passes through 2 flops to give rx_s, plus a third flop for edge detection. A start is a falling edge of rx_s seen in IDLE.
- Counters:
  - 16-bit baud counter, loaded and counting down.
  - 4-bit bit counter.
  - 9-bit shift register, shifting right with the new bit entering at MSB.
- State machine:
  - IDLE: on start, load the baud counter with HALF_DIV and go to START.
  - START: at count 0, sample rx_s.
    - If 1 (glitch), return to IDLE with no output change.
    - If 0, load BAUD_DIV, clear the bit counter, go to DATA.
  - DATA: at each count 0:
    - Shift rx_s in, increment the bit counter, reload BAUD_DIV.
    - After the 8th data bit go to STOP.
  - STOP: at count 0, sample the stop bit and complete the frame:
    - rx_data <= the 8 data bits (first-received bit = bit 0).
    - frm_err <= ~stop_bit.
    - ovr_err <= ovr_err | rdy.
    - rdy <= 1.
    - Go to IDLE. The byte is delivered even when frm_err is set.
- Latency: rdy rises 1 clk after the stop-bit midpoint, about 9.5*BAUD_DIV + 3 clks after the RX falling edge.
- Handshake:
  - clr_rdy=1 clears rdy, frm_err and ovr_err on the next clk edge; rx_data is kept.
  - If clr_rdy coincides with frame completion, completion wins: rdy=1 with the new data, ovr_err=0, frm_err reflects the new frame.
  - clr_rdy while rdy=0 has no effect.
- Back-to-back frames: the FSM returns to IDLE at the stop-bit midpoint, so the next start edge up to 0.5 bit later is caught. No minimum idle time is required beyond the stop half-bit.
- Break (RX held low):
  - The frame completes with frm_err=1 and data 8'h00.
  - No new start is detected until rx_s returns high and falls again.
- Reset asserted mid-frame: all state returns to reset values immediately. The rest of the frame is ignored until a fresh falling edge after rst deasserts.
- The shift register and counters are not visible at the ports; only the outputs listed above are observable.

Test Plan:
- Baseline frame: after rst, UART_tx sends 8'h67 at BAUD_DIV=5208.
  - rdy rises about 49,480 clks after the start edge.
  - rx_data=8'h67, frm_err=0, ovr_err=0.
  - clr_rdy pulse -> rdy=0 next clk and rx_data stays 8'h67.
- Back-to-back bytes: 8'h55 then 8'hAA with zero idle time, clr_rdy pulsed after each rdy -> both bytes received correctly with no error flags.
- Overrun: send 8'h12, do not clear, then send 8'h34.
  - rx_data=8'h34, rdy=1, ovr_err=1.
  - clr_rdy -> ovr_err=0 and rdy=0.
- Framing error: drive a bit-banged frame of 8'hF0 with the stop bit held low -> rx_data=8'hF0, rdy=1, frm_err=1.
- Glitch rejection: a 1000-clk low pulse on idle RX -> the FSM returns to IDLE and rdy stays 0. A following 8'h73 is received correctly.
- Reset mid-frame: assert rst during data bit 4 of 8'hA5.
  - rdy=0 and rx_data=8'h00 immediately.
  - After release, the remaining bits cause no rdy. The next full frame 8'h67 is received correctly.
  - Separately, clr_rdy asserted in the exact completion cycle leaves rdy=1.

Source files
------------

// File: rtl/uart_rcv.sv
// 8N1 UART receiver: LSB-first serial bytes from RX are framed, checked for
// stop-bit and overrun errors, and handed out through a rdy/clr_rdy handshake.
module uart_rcv #(
    parameter int unsigned BAUD_DIV = 5208,
    parameter int unsigned HALF_DIV = BAUD_DIV / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err,
    output logic       ovr_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // The action fires on the clock after the counter reaches zero, so load N-1
    // to get exactly N clocks per interval.
    localparam logic [15:0] BAUD_LD = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF_LD = 16'(HALF_DIV - 1);

    logic        sync1_q, sync2_q, sync3_q;
    logic        rx_s, start_s, baud_done_s;
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [8:0]  shift_q, shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rdy_q, rdy_d;
    logic        frm_err_q, frm_err_d;
    logic        ovr_err_q, ovr_err_d;

    assign rx_s        = sync2_q;
    assign start_s     = sync3_q & ~sync2_q;
    assign baud_done_s = (cnt_q == 16'd0);

    // Synchronizer and edge-detect flops, preset high so reset never looks like a start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            sync3_q <= 1'b1;
        end else begin
            sync1_q <= RX;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // Receiver state, counters, shift register and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 16'd0;
            bit_cnt_q <= 4'd0;
            shift_q   <= 9'd0;
            rx_data_q <= 8'h00;
            rdy_q     <= 1'b0;
            frm_err_q <= 1'b0;
            ovr_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            rx_data_q <= rx_data_d;
            rdy_q     <= rdy_d;
            frm_err_q <= frm_err_d;
            ovr_err_q <= ovr_err_d;
        end
    end

    // Next-state and handshake logic; frame completion overrides a coincident clear.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        rx_data_d = rx_data_q;
        rdy_d     = rdy_q;
        frm_err_d = frm_err_q;
        ovr_err_d = ovr_err_q;

        if (clr_rdy) begin
            rdy_d     = 1'b0;
            frm_err_d = 1'b0;
            ovr_err_d = 1'b0;
        end else begin
            rdy_d     = rdy_q;
            frm_err_d = frm_err_q;
            ovr_err_d = ovr_err_q;
        end

        case (state_q)
            IDLE: begin
                if (start_s) begin
                    cnt_d   = HALF_LD;
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (!baud_done_s) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (rx_s) begin
                    state_d = IDLE;
                end else begin
                    // The start bit rides along in the shift register and ends up in bit 0.
                    shift_d   = {rx_s, shift_q[8:1]};
                    cnt_d     = BAUD_LD;
                    bit_cnt_d = 4'd0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (baud_done_s) begin
                    shift_d   = {rx_s, shift_q[8:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    cnt_d     = BAUD_LD;
                    if (bit_cnt_q == 4'd7) begin
                        state_d = STOP;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            STOP: begin
                if (baud_done_s) begin
                    rx_data_d = shift_q[8:1];
                    frm_err_d = ~rx_s | shift_q[0];
                    ovr_err_d = clr_rdy ? 1'b0 : (ovr_err_q | rdy_q);
                    rdy_d     = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rx_data = rx_data_q;
    assign rdy     = rdy_q;
    assign frm_err = frm_err_q;
    assign ovr_err = ovr_err_q;

endmodule

// File: tb/tb_uart_rcv.sv
// Randomized self-checking bench for uart_rcv, compared against a
// transaction-level model of the rdy/frm_err/ovr_err handshake.
module tb_uart_rcv;

    localparam int B = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       RX;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;
    logic       ovr_err;

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;
    int t_start;
    int t_rdy;

    logic [7:0] m_data;
    logic       m_rdy, m_frm, m_ovr;

    uart_rcv #(.BAUD_DIV(B)) dut (
        .clk     (clk),
        .rst     (rst),
        .RX      (RX),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rdy     (rdy),
        .frm_err (frm_err),
        .ovr_err (ovr_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_data"}, {24'd0, rx_data}, {24'd0, m_data});
        chk({tag, "_rdy"},  {31'd0, rdy},     {31'd0, m_rdy});
        chk({tag, "_frm"},  {31'd0, frm_err}, {31'd0, m_frm});
        chk({tag, "_ovr"},  {31'd0, ovr_err}, {31'd0, m_ovr});
    endtask

    function automatic void model_frame(input logic [7:0] b, input logic stop);
        m_ovr  = m_ovr | m_rdy;
        m_rdy  = 1'b1;
        m_data = b;
        m_frm  = ~stop;
    endfunction

    function automatic void model_clear();
        m_rdy = 1'b0;
        m_frm = 1'b0;
        m_ovr = 1'b0;
    endfunction

    function automatic void model_reset();
        model_clear();
        m_data = 8'h00;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Entered and left on a falling clock edge; RX is left high.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        RX = 1'b0;
        t_start = cyc;
        idle(B);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            idle(B);
        end
        RX = stop;
        idle(B);
        RX = 1'b1;
    endtask

    task automatic pulse_clr();
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
        model_clear();
    endtask

    task automatic wait_rdy(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 12 * B; k++) begin
            if (rdy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        bit         ok;
        int         lat;
        logic [7:0] rb;
        logic       rs;
        int         gap;

        rst = 1'b1;
        RX = 1'b1;
        clr_rdy = 1'b0;
        model_reset();
        idle(3);
        check_all("reset");
        rst = 1'b0;
        idle(2);

        // Baseline frame with latency measurement
        fork
            send_frame(8'h67, 1'b1);
            begin
                @(negedge clk);
                wait_rdy(ok);
                t_rdy = cyc;
            end
        join
        chk("base_seen", {31'd0, ok}, 32'd1);
        lat = t_rdy - t_start;
        chk("base_lat_window", {31'd0, (lat >= 9 * B + B / 2) && (lat <= 9 * B + B / 2 + 6)}, 32'd1);
        model_frame(8'h67, 1'b1);
        check_all("base");
        pulse_clr();
        check_all("base_clr");

        // Back-to-back bytes, cleared while the next frame is in flight
        fork
            begin
                send_frame(8'h55, 1'b1);
                send_frame(8'hAA, 1'b1);
            end
            begin
                wait_rdy(ok);
                chk("b2b_seen1", {31'd0, ok}, 32'd1);
                model_frame(8'h55, 1'b1);
                check_all("b2b1");
                pulse_clr();
                wait_rdy(ok);
                chk("b2b_seen2", {31'd0, ok}, 32'd1);
                model_frame(8'hAA, 1'b1);
                check_all("b2b2");
                pulse_clr();
            end
        join
        idle(B);

        // Overrun
        send_frame(8'h12, 1'b1);
        model_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        model_frame(8'h34, 1'b1);
        check_all("ovr");
        pulse_clr();
        check_all("ovr_clr");

        // Framing error: data delivered anyway
        send_frame(8'hF0, 1'b0);
        idle(B);
        model_frame(8'hF0, 1'b0);
        check_all("frm");
        pulse_clr();

        // Break: one errored all-zero frame, nothing more until RX rises and falls again
        RX = 1'b0;
        idle(14 * B);
        RX = 1'b1;
        model_frame(8'h00, 1'b0);
        check_all("brk");
        idle(3 * B);
        check_all("brk_idle");
        pulse_clr();

        // Glitch shorter than half a bit
        RX = 1'b0;
        idle(B / 4);
        RX = 1'b1;
        idle(12 * B);
        check_all("glitch");
        send_frame(8'h73, 1'b1);
        model_frame(8'h73, 1'b1);
        check_all("glitch_next");
        pulse_clr();

        // Reset during data bit 4 of 8'hA5, released during the high bit 7
        RX = 1'b0;
        idle(B);
        rb = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            RX = rb[i];
            idle(B);
        end
        RX = rb[4];
        idle(B / 2);
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rst_mid");
        @(negedge clk);
        idle(B / 2 - 1);
        RX = rb[5];
        idle(B);
        RX = rb[6];
        idle(B);
        RX = rb[7];
        idle(B / 2);
        rst = 1'b0;
        idle(B / 2);
        RX = 1'b1;
        idle(12 * B);
        check_all("rst_rest");
        send_frame(8'h67, 1'b1);
        model_frame(8'h67, 1'b1);
        check_all("rst_next");

        // clr_rdy held through the completion cycle: completion wins
        fork
            send_frame(8'h3C, 1'b1);
            begin
                clr_rdy = 1'b1;
                @(negedge clk);
                wait_rdy(ok);
                clr_rdy = 1'b0;
                chk("coin_seen", {31'd0, ok}, 32'd1);
            end
        join
        m_rdy  = 1'b1;
        m_data = 8'h3C;
        m_frm  = 1'b0;
        m_ovr  = 1'b0;
        check_all("coin");
        pulse_clr();

        // Randomized frames, stop bits, gaps and clears
        for (int n = 0; n < 20; n++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 4) != 0);
            send_frame(rb, rs);
            model_frame(rb, rs);
            check_all("rand");
            if ($urandom_range(0, 1) == 1) begin
                pulse_clr();
            end
            gap = rs ? int'($urandom_range(0, 1)) * int'($urandom_range(0, B)) : B;
            idle(gap);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
